// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM state
// encodings, default ack byte and the bundle lane layout.
package imem_boot_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_HDR    = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_LAUNCH = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;

    // Bundle layout: lane 0 is the most significant 32 bits of the bundle
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 32;
    localparam int BUNDLE_W  = NUM_LANES * LANE_W;

    function automatic int lane_msb(input logic [1:0] lane);
        return BUNDLE_W - 1 - LANE_W * int'(lane);
    endfunction

    function automatic int lane_lsb(input logic [1:0] lane);
        return lane_msb(lane) - LANE_W + 1;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot loader bus: uart_rx byte input, imem write port, fetch redirect,
// uart_tx ack and status. master = loader side, slave = its neighbours.
interface imem_boot_loader_if #(
    parameter int BUNDLE_AW = 14
);
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 wr_ready;
    logic                 wr_en;
    logic [BUNDLE_AW-1:0] wr_bundle;
    logic [1:0]           wr_lane;
    logic [31:0]          wr_data;
    logic                 core_hold;
    logic                 npc_en;
    logic [BUNDLE_AW-1:0] npc;
    logic                 ack_valid;
    logic [7:0]           ack_data;
    logic                 load_err;
    logic                 busy;

    modport master (
        input  rx_valid, rx_data, wr_ready,
        output wr_en, wr_bundle, wr_lane, wr_data, core_hold,
               npc_en, npc, ack_valid, ack_data, load_err, busy
    );

    modport slave (
        output rx_valid, rx_data, wr_ready,
        input  wr_en, wr_bundle, wr_lane, wr_data, core_hold,
               npc_en, npc, ack_valid, ack_data, load_err, busy
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// MSB-first byte-to-word assembler. word/word_done are combinational on the
// cycle the 4th byte arrives so the caller can register the word directly.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);
    logic [23:0] sr;
    logic [1:0]  cnt;

    assign word_done = byte_valid && (cnt == 2'd3);
    assign word      = {sr, byte_in};

    // Shift in bytes and count position within the word
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (byte_valid) begin
            sr  <= {sr[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a word count plus instruction stream from the UART,
// writes instructions into their bundle lanes, then redirects fetch to
// START_PC and releases the core stall.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int                   BUNDLE_AW = 14,
    parameter logic [BUNDLE_AW-1:0] START_PC  = '0,
    parameter logic [7:0]           ACK_BYTE  = ACK_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    imem_boot_loader_if.master bus
);
    // Largest legal count; 33 bits so the compare never overflows
    localparam logic [32:0] CAPACITY = 33'd4 << BUNDLE_AW;

    logic [2:0]           state, state_d;
    logic [31:0]          n_words;
    logic [BUNDLE_AW+1:0] idx;      // index of the word at the write port
    logic [BUNDLE_AW+1:0] asm_cnt;  // words assembled so far
    logic                 wr_en_q;
    logic [31:0]          wr_data_q;
    logic                 core_hold_q, npc_en_q, ack_valid_q, load_err_q, busy_q;

    logic        pk_active;
    logic [31:0] pk_word;
    logic        pk_done;
    logic        accept;
    logic        is_last;

    // Bytes are only consumed while collecting the header or the payload
    assign pk_active = (state == ST_HDR) || (state == ST_LOAD);
    assign accept    = wr_en_q && bus.wr_ready;
    assign is_last   = (32'(asm_cnt) == n_words - 32'd1);

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (!pk_active),
        .byte_valid (bus.rx_valid && pk_active),
        .byte_in    (bus.rx_data),
        .word       (pk_word),
        .word_done  (pk_done)
    );

    // Next-state decode
    always_comb begin
        state_d = state;
        case (state)
            ST_HDR: begin
                if (pk_done) begin
                    if (pk_word == 32'd0)
                        state_d = ST_LAUNCH;
                    else if ({1'b0, pk_word} > CAPACITY)
                        state_d = ST_ERR;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A new word with the previous one still stuck is an overrun
                if (pk_done && wr_en_q && !bus.wr_ready)
                    state_d = ST_ERR;
                else if (pk_done && is_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN:  if (accept) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_HDR;
        endcase
    end

    // State, counters, write port and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HDR;
            n_words     <= '0;
            idx         <= '0;
            asm_cnt     <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            core_hold_q <= 1'b1;
            npc_en_q    <= 1'b0;
            ack_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state <= state_d;

            if (state == ST_HDR && pk_done)
                n_words <= pk_word;

            if (state == ST_LOAD && pk_done)
                asm_cnt <= asm_cnt + 1'b1;

            // An overrun drops the pending write; otherwise a completed word
            // takes the port (possibly in the same cycle the old one leaves)
            if (state_d == ST_ERR) begin
                wr_en_q <= 1'b0;
            end else if (state == ST_LOAD && pk_done) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= pk_word;
            end else if (accept) begin
                wr_en_q <= 1'b0;
            end

            if (accept)
                idx <= idx + 1'b1;

            // Hold drops together with the redirect strobe and stays low
            core_hold_q <= !((state_d == ST_LAUNCH) || (state_d == ST_RUN));
            npc_en_q    <= (state_d == ST_LAUNCH);
            ack_valid_q <= (state_d == ST_LAUNCH);
            load_err_q  <= (state_d == ST_ERR);
            busy_q      <= !((state_d == ST_RUN) || (state_d == ST_ERR));
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_bundle = idx[BUNDLE_AW+1:2];
    assign bus.wr_lane   = idx[1:0];
    assign bus.core_hold = core_hold_q;
    assign bus.npc_en    = npc_en_q;
    assign bus.npc       = START_PC;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_data  = ACK_BYTE;
    assign bus.load_err  = load_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. Inputs change 1 ns after posedge;
// a negedge monitor logs accepted writes and the launch strobe.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.BUNDLE_AW(14)) bus ();

    imem_boot_loader #(.BUNDLE_AW(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          bundle;
        int          lane;
        logic [31:0] data;
    } wrec_t;

    wrec_t       wq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          npc_cnt = 0;
    int          npc_cyc = -1;
    int          acc_cyc = -1;
    int          wen_cnt = 0;
    int          last_byte_cyc = 0;
    logic [13:0] npc_val;
    logic [7:0]  ackd_at_npc;
    logic        ack_at_npc, hold_at_npc, hold_before_npc;
    logic        prev_hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Log what the DUT presents in each cycle
    always @(negedge clk) begin
        if (bus.wr_en) wen_cnt++;
        if (bus.wr_en && bus.wr_ready) begin
            wq.push_back('{int'(bus.wr_bundle), int'(bus.wr_lane), bus.wr_data});
            acc_cyc = cyc;
        end
        if (bus.npc_en) begin
            npc_cnt++;
            npc_cyc         = cyc;
            npc_val         = bus.npc;
            ackd_at_npc     = bus.ack_data;
            ack_at_npc      = bus.ack_valid;
            hold_at_npc     = bus.core_hold;
            hold_before_npc = prev_hold;
        end
        prev_hold = bus.core_hold;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid  = 1'b1;
        bus.rx_data   = b;
        last_byte_cyc = cyc;
        tick();
        bus.rx_valid  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic clear_log();
        wq.delete();
        npc_cnt = 0;
        npc_cyc = -1;
        acc_cyc = -1;
        wen_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic wait_launch(input int budget);
        for (int i = 0; i < budget && npc_cnt == 0; i++) tick();
        checks++;
        if (npc_cnt == 0) begin
            errors++;
            $display("FAIL launch_timeout: no npc_en within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.wr_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.wr_en !== 1'b0)     begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL rst_core_hold: got %b want 1", bus.core_hold); end
        checks++; if (bus.npc_en !== 1'b0)    begin errors++; $display("FAIL rst_npc_en: got %b want 0", bus.npc_en); end
        checks++; if (bus.ack_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_valid: got %b want 0", bus.ack_valid); end
        checks++; if (bus.load_err !== 1'b0)  begin errors++; $display("FAIL rst_load_err: got %b want 0", bus.load_err); end
        checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_three_words();
        logic [31:0] exp_w[3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        send_word(32'd3);
        for (int i = 0; i < 3; i++) send_word(exp_w[i]);
        wait_launch(10);
        tick(); tick(); tick();
        checks++; if (wq.size() !== 3) begin errors++; $display("FAIL w3_count: got %0d want 3", wq.size()); end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].bundle !== 0 || wq[i].lane !== i || wq[i].data !== exp_w[i]) begin
                errors++;
                $display("FAIL w3_write%0d: got b%0d l%0d %h want b0 l%0d %h",
                         i, wq[i].bundle, wq[i].lane, wq[i].data, i, exp_w[i]);
            end
        end
        checks++; if (npc_cnt !== 1)          begin errors++; $display("FAIL w3_npc_count: got %0d want 1", npc_cnt); end
        checks++; if (npc_val !== 14'd0)      begin errors++; $display("FAIL w3_npc: got %h want 0", npc_val); end
        checks++; if (ack_at_npc !== 1'b1)    begin errors++; $display("FAIL w3_ack_valid: got %b want 1", ack_at_npc); end
        checks++; if (ackd_at_npc !== 8'hAA)  begin errors++; $display("FAIL w3_ack_data: got %h want aa", ackd_at_npc); end
        checks++; if (hold_before_npc !== 1'b1) begin errors++; $display("FAIL w3_hold_before: got %b want 1", hold_before_npc); end
        checks++; if (hold_at_npc !== 1'b0)   begin errors++; $display("FAIL w3_hold_at_npc: got %b want 0", hold_at_npc); end
        checks++; if (npc_cyc !== acc_cyc + 1) begin errors++; $display("FAIL w3_latency: npc cycle %0d accept cycle %0d want +1", npc_cyc, acc_cyc); end
        // RUN ignores further bytes
        send_word(32'h01020304);
        tick(); tick();
        checks++; if (wq.size() !== 3)        begin errors++; $display("FAIL run_ignore_wr: got %0d writes want 3", wq.size()); end
        checks++; if (npc_cnt !== 1)          begin errors++; $display("FAIL run_ignore_npc: got %0d want 1", npc_cnt); end
        checks++; if (bus.core_hold !== 1'b0) begin errors++; $display("FAIL run_hold: got %b want 0", bus.core_hold); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL run_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_zero_count();
        int hdr_cyc;
        do_reset();
        send_word(32'd0);
        hdr_cyc = last_byte_cyc;
        wait_launch(5);
        tick();
        checks++; if (wen_cnt !== 0)           begin errors++; $display("FAIL zero_wr_en: got %0d cycles want 0", wen_cnt); end
        checks++; if (npc_cyc !== hdr_cyc + 1) begin errors++; $display("FAIL zero_launch: got cycle %0d want %0d", npc_cyc, hdr_cyc + 1); end
        checks++; if (npc_cnt !== 1)           begin errors++; $display("FAIL zero_npc_count: got %0d want 1", npc_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[5] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};
        do_reset();
        bus.wr_ready = 1'b1;
        send_word(32'd5);
        for (int i = 0; i < 5; i++) send_word(w[i]);
        // Word 5 is now at the port; stall it for 3 cycles
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_bundle !== 14'd1 || bus.wr_lane !== 2'd0 || bus.wr_data !== w[4]) begin
                errors++;
                $display("FAIL stall_hold%0d: got en%b b%0d l%0d %h want en1 b1 l0 %h",
                         i, bus.wr_en, bus.wr_bundle, bus.wr_lane, bus.wr_data, w[4]);
            end
            tick();
        end
        bus.wr_ready = 1'b1;
        tick();
        checks++; if (bus.npc_en !== 1'b1) begin errors++; $display("FAIL stall_npc: got %b want 1", bus.npc_en); end
        tick();
        checks++; if (wq.size() !== 5) begin errors++; $display("FAIL stall_count: got %0d want 5", wq.size()); end
        if (wq.size() == 5) begin
            checks++;
            if (wq[3].bundle !== 0 || wq[3].lane !== 3 || wq[3].data !== w[3]) begin
                errors++; $display("FAIL stall_w4: got b%0d l%0d %h want b0 l3 %h", wq[3].bundle, wq[3].lane, wq[3].data, w[3]);
            end
            checks++;
            if (wq[4].bundle !== 1 || wq[4].lane !== 0 || wq[4].data !== w[4]) begin
                errors++; $display("FAIL stall_w5: got b%0d l%0d %h want b1 l0 %h", wq[4].bundle, wq[4].lane, wq[4].data, w[4]);
            end
        end
        checks++; if (npc_cyc !== acc_cyc + 1) begin errors++; $display("FAIL stall_latency: npc cycle %0d accept cycle %0d want +1", npc_cyc, acc_cyc); end
    endtask

    task automatic test_overrun();
        do_reset();
        bus.wr_ready = 1'b0;
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        tick(); tick();
        checks++; if (bus.load_err !== 1'b1)  begin errors++; $display("FAIL ovr_err: got %b want 1", bus.load_err); end
        checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL ovr_hold: got %b want 1", bus.core_hold); end
        checks++; if (bus.wr_en !== 1'b0)     begin errors++; $display("FAIL ovr_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL ovr_busy: got %b want 0", bus.busy); end
        bus.wr_ready = 1'b1;
        send_word(32'h00000001);
        tick(); tick();
        checks++; if (npc_cnt !== 0)          begin errors++; $display("FAIL ovr_npc: got %0d want 0", npc_cnt); end
        checks++; if (wq.size() !== 0)        begin errors++; $display("FAIL ovr_writes: got %0d want 0", wq.size()); end
        checks++; if (bus.load_err !== 1'b1)  begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.load_err); end
    endtask

    task automatic test_oversize();
        do_reset();
        bus.wr_ready = 1'b1;
        send_word(32'h00010001);
        tick();
        checks++; if (bus.load_err !== 1'b1)  begin errors++; $display("FAIL big_err: got %b want 1", bus.load_err); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL big_busy: got %b want 0", bus.busy); end
        checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL big_hold: got %b want 1", bus.core_hold); end
        // Exactly full capacity is legal
        do_reset();
        send_word(32'h00010000);
        tick();
        checks++; if (bus.load_err !== 1'b0)  begin errors++; $display("FAIL cap_err: got %b want 0", bus.load_err); end
        checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL cap_busy: got %b want 1", bus.busy); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        bus.wr_ready = 1'b1;
        send_word(32'd2);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.wr_en !== 1'b0)     begin errors++; $display("FAIL mid_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL mid_hold: got %b want 1", bus.core_hold); end
        checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        clear_log();
        send_word(32'd1);
        send_word(32'hDEADBEEF);
        wait_launch(10);
        tick();
        checks++; if (wq.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", wq.size()); end
        if (wq.size() == 1) begin
            checks++;
            if (wq[0].bundle !== 0 || wq[0].lane !== 0 || wq[0].data !== 32'hDEADBEEF) begin
                errors++; $display("FAIL mid_write: got b%0d l%0d %h want b0 l0 deadbeef", wq[0].bundle, wq[0].lane, wq[0].data);
            end
        end
        checks++; if (npc_cnt !== 1) begin errors++; $display("FAIL mid_npc: got %0d want 1", npc_cnt); end
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_zero_count();
        test_back_to_back();
        test_overrun();
        test_oversize();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
